// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer.
//
// Sits downstream of the baud generator and uses its OVERSAMPLE x baud strobe
// (sample_ENABLE) to find start bits, sample each bit at mid-bit and assemble
// LSB-first frames. Every completed frame produces a one-clk pulse on exactly one
// of Rx_VALID, Rx_FERROR or Rx_PERROR.
//
// Optional feature: define UART_RX_PARITY_EN to expect an even-parity bit between
// the last data bit and the stop bit. Without it the frame is 8N1 and Rx_PERROR is
// tied low.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   sample_ENABLE one-clk oversampling strobe (OVERSAMPLE per bit period)
//   Rx_EN         receiver enable; low returns the receiver to idle
//   RxD           asynchronous serial line, idle high
//   Rx_DATA       last received byte (held between frames)
//   Rx_VALID      one-clk pulse: good frame in Rx_DATA
//   Rx_FERROR     one-clk pulse: stop bit sampled low
//   Rx_PERROR     one-clk pulse: parity mismatch (parity builds only)

module uart_rx_deserializer #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_ENABLE,
    input  logic                 Rx_EN,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_FERROR,
    output logic                 Rx_PERROR
);

    localparam logic [3:0] TickMid  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] TickLast = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] BitLast  = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e                 state_q, state_d;
    logic                   rx_meta_q, rxs_q;
    logic [3:0]             tick_q, tick_d;
    logic [2:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferror_q, ferror_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_err_q, par_err_d;
    logic                   perror_q, perror_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferror_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
            perror_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rx_meta_q <= RxD;
            rxs_q     <= rx_meta_q;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferror_q  <= ferror_d;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
            perror_q  <= perror_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferror_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
        perror_d  = 1'b0;
`endif
        if (!Rx_EN) begin
            // Partial frame is dropped silently; Rx_DATA keeps its last value.
            state_d = StIdle;
            tick_d  = '0;
            bit_d   = '0;
        end else if (sample_ENABLE) begin
            unique case (state_q)
                StIdle: begin
                    if (!rxs_q) begin
                        state_d = StStart;
                        tick_d  = '0;
                    end
                end
                StStart: begin
                    if (tick_q == TickMid) begin
                        tick_d = '0;
                        // High at mid-start means the low level was a glitch.
                        if (rxs_q) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StData;
                            bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                            par_err_d = 1'b0;
`endif
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                StData: begin
                    if (tick_q == TickLast) begin
                        tick_d  = '0;
                        shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BitLast) begin
                            bit_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d = StParity;
`else
                            state_d = StStop;
`endif
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (tick_q == TickLast) begin
                        tick_d    = '0;
                        // Even parity: data bits plus parity bit must XOR to zero.
                        par_err_d = ^{shift_q, rxs_q};
                        state_d   = StStop;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
`endif
                StStop: begin
                    if (tick_q == TickLast) begin
                        tick_d  = '0;
                        data_d  = shift_q;
                        // Back to idle right at mid-stop so a following start bit
                        // half a bit later is not missed.
                        state_d = StIdle;
                        if (!rxs_q) begin
                            ferror_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_err_q) begin
                            perror_d = 1'b1;
`endif
                        end else begin
                            valid_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            endcase
        end
    end

    assign Rx_DATA   = data_q;
    assign Rx_VALID  = valid_q;
    assign Rx_FERROR = ferror_q;
`ifdef UART_RX_PARITY_EN
    assign Rx_PERROR = perror_q;
`else
    assign Rx_PERROR = 1'b0;
`endif

endmodule
